// File: rtl/hwag_spi_regfile.sv
// SPI frame decoder and HWAG configuration register bank.
// Collects [CMD][ADDR][DATA32 LSB-first][CRC8], checks the CRC, and commits writes or latches reads.
module hwag_spi_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_ss,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic [7:0]  crc_in,
  output logic [31:0] cfg_ctrl,
  output logic [3:0]  cfg_stwd,
  output logic [23:0] cfg_maxacr,
  output logic [18:0] cfg_filt_nogap,
  output logic [18:0] cfg_filt_gap,
  output logic [23:0] cfg_dwell_div,
  output logic [23:0] cfg_off14,
  output logic [23:0] cfg_off23,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  last_err,
  output logic [7:0]  err_cnt
);
  localparam int FRAME_LEN = 7;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [1:0] E_CRC = 2'd1, E_SHORT = 2'd2, E_CMD = 2'd3;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [7:0]  r_slot [FRAME_LEN];
  logic [7:0]  r_crc_exp;
  logic        r_pending;

  logic [31:0] r_ctrl;
  logic [3:0]  r_stwd;
  logic [23:0] r_maxacr;
  logic [18:0] r_filt_nogap;
  logic [18:0] r_filt_gap;
  logic [23:0] r_dwell_div;
  logic [23:0] r_off14;
  logic [23:0] r_off23;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_frame_ok;
  logic        r_frame_err;
  logic [1:0]  r_last_err;
  logic [7:0]  r_err_cnt;

  logic [7:0]  w_cmd, w_addr;
  logic [31:0] w_data, w_rd_mux;
  logic        w_crc_bad, w_cmd_bad, w_eval, w_short, w_ok, w_err;
  logic [1:0]  w_err_code;

  assign w_cmd     = r_slot[0];
  assign w_addr    = r_slot[1];
  assign w_data    = {r_slot[5], r_slot[4], r_slot[3], r_slot[2]};
  assign w_crc_bad = (r_slot[6] != r_crc_exp);
  assign w_cmd_bad = !((w_cmd == CMD_WR) || (w_cmd == CMD_RD)) || (w_addr > 8'h07);
  // One evaluation per completed frame, in the first DONE cycle.
  assign w_eval    = (r_state == DONE) && r_pending;
  assign w_short   = (r_state == RECV) && spi_ss && (r_idx != 3'd0);
  assign w_ok      = w_eval && !w_crc_bad && !w_cmd_bad;
  assign w_err     = w_short || (w_eval && (w_crc_bad || w_cmd_bad));
  assign w_err_code = w_short ? E_SHORT : (w_crc_bad ? E_CRC : E_CMD);

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_addr[2:0])
      3'd0: w_rd_mux = r_ctrl;
      3'd1: w_rd_mux = {28'd0, r_stwd};
      3'd2: w_rd_mux = {8'd0, r_maxacr};
      3'd3: w_rd_mux = {13'd0, r_filt_nogap};
      3'd4: w_rd_mux = {13'd0, r_filt_gap};
      3'd5: w_rd_mux = {8'd0, r_dwell_div};
      3'd6: w_rd_mux = {8'd0, r_off14};
      3'd7: w_rd_mux = {8'd0, r_off23};
      default: w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= 3'd0;
      r_pending    <= 1'b0;
      r_crc_exp    <= 8'd0;
      for (int i = 0; i < FRAME_LEN; i++) r_slot[i] <= 8'd0;
      r_ctrl       <= 32'd0;
      r_stwd       <= 4'd4;
      r_maxacr     <= 24'd3839;
      r_filt_nogap <= 19'd45;
      r_filt_gap   <= 19'd134;
      r_dwell_div  <= 24'd50000;
      r_off14      <= 24'd2752;
      r_off23      <= 24'd832;
      r_rd_data    <= 32'd0;
      r_rd_valid   <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_last_err   <= 2'd0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_frame_ok  <= w_ok;
      r_frame_err <= w_err;
      if (w_err) begin
        r_last_err <= w_err_code;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end

      if (spi_ss) begin
        r_state   <= IDLE;
        r_idx     <= 3'd0;
        r_pending <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= RECV;
            r_idx   <= 3'd0;
          end
          RECV: if (rx_valid) begin
            r_slot[r_idx] <= rx_byte;
            r_rd_valid    <= 1'b0;
            if (r_idx == 3'(FRAME_LEN - 2)) r_crc_exp <= crc_in;
            if (r_idx == 3'(FRAME_LEN - 1)) begin
              r_state   <= DONE;
              r_pending <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
          DONE:    r_pending <= 1'b0;
          default: r_state <= IDLE;
        endcase
      end

      // Commit happens even if select rises in the evaluation cycle.
      if (w_ok) begin
        if (w_cmd == CMD_WR) begin
          case (w_addr[2:0])
            3'd0: r_ctrl       <= w_data;
            3'd1: r_stwd       <= w_data[3:0];
            3'd2: r_maxacr     <= w_data[23:0];
            3'd3: r_filt_nogap <= w_data[18:0];
            3'd4: r_filt_gap   <= w_data[18:0];
            3'd5: r_dwell_div  <= w_data[23:0];
            3'd6: r_off14      <= w_data[23:0];
            3'd7: r_off23      <= w_data[23:0];
            default: ;
          endcase
        end else begin
          r_rd_data  <= w_rd_mux;
          r_rd_valid <= 1'b1;
        end
      end
    end
  end

  assign cfg_ctrl       = r_ctrl;
  assign cfg_stwd       = r_stwd;
  assign cfg_maxacr     = r_maxacr;
  assign cfg_filt_nogap = r_filt_nogap;
  assign cfg_filt_gap   = r_filt_gap;
  assign cfg_dwell_div  = r_dwell_div;
  assign cfg_off14      = r_off14;
  assign cfg_off23      = r_off23;
  assign rd_data        = r_rd_data;
  assign rd_valid       = r_rd_valid;
  assign frame_ok       = r_frame_ok;
  assign frame_err      = r_frame_err;
  assign last_err       = r_last_err;
  assign err_cnt        = r_err_cnt;
endmodule

// File: tb/tb_hwag_spi_regfile.sv
// Randomized bench for hwag_spi_regfile against a frame-level register-bank model.
module tb_hwag_spi_regfile;
  logic        clk = 0, rst = 1, spi_ss = 1, rx_valid = 0;
  logic [7:0]  rx_byte = 0, crc_in = 0;
  logic [31:0] cfg_ctrl, rd_data;
  logic [3:0]  cfg_stwd;
  logic [23:0] cfg_maxacr, cfg_dwell_div, cfg_off14, cfg_off23;
  logic [18:0] cfg_filt_nogap, cfg_filt_gap;
  logic        rd_valid, frame_ok, frame_err;
  logic [1:0]  last_err;
  logic [7:0]  err_cnt;

  hwag_spi_regfile dut (
    .clk(clk), .rst(rst), .spi_ss(spi_ss), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .crc_in(crc_in), .cfg_ctrl(cfg_ctrl), .cfg_stwd(cfg_stwd), .cfg_maxacr(cfg_maxacr),
    .cfg_filt_nogap(cfg_filt_nogap), .cfg_filt_gap(cfg_filt_gap),
    .cfg_dwell_div(cfg_dwell_div), .cfg_off14(cfg_off14), .cfg_off23(cfg_off23),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_ok(frame_ok), .frame_err(frame_err),
    .last_err(last_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int g_gap = 1;
  bit g_extra = 0;
  logic [7:0] fb [7];

  // Model state: register values, widths, read-back and error bookkeeping.
  logic [31:0] m_reg [8];
  int          m_w   [8] = '{32, 4, 24, 19, 19, 24, 24, 24};
  logic [31:0] m_rst [8] = '{32'd0, 32'd4, 32'd3839, 32'd45, 32'd134, 32'd50000, 32'd2752, 32'd832};
  logic [31:0] m_rd_data;
  logic        m_rd_valid;
  logic [1:0]  m_last_err;
  int          m_err_cnt;
  int          m_outcome;  // 0 nothing, 1 accepted, 2 rejected
  logic s_pre_ok, s_pre_err, s_ok, s_err, s_post_ok, s_post_err;

  function automatic logic [7:0] crc8(input int n);
    logic [7:0] c = 8'h00;
    for (int k = 0; k < n; k++) begin
      c = c ^ fb[k];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] cfg_of(input int i);
    case (i)
      0: return cfg_ctrl;
      1: return {28'd0, cfg_stwd};
      2: return {8'd0, cfg_maxacr};
      3: return {13'd0, cfg_filt_nogap};
      4: return {13'd0, cfg_filt_gap};
      5: return {8'd0, cfg_dwell_div};
      6: return {8'd0, cfg_off14};
      default: return {8'd0, cfg_off23};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = m_rst[i];
    m_rd_data = 0; m_rd_valid = 0; m_last_err = 0; m_err_cnt = 0; m_outcome = 0;
  endtask

  task automatic model_reject(input logic [1:0] code);
    m_outcome = 2; m_last_err = code;
    if (m_err_cnt < 255) m_err_cnt++;
  endtask

  task automatic model_frame(input int nb);
    logic [31:0] d;
    int a;
    m_outcome = 0;
    if (nb >= 1) m_rd_valid = 0;
    if (nb == 0) return;
    if (nb < 7) begin model_reject(2); return; end
    if (fb[6] != crc8(6)) begin model_reject(1); return; end
    if (!(fb[0] == 8'h01 || fb[0] == 8'h02) || fb[1] > 8'h07) begin model_reject(3); return; end
    m_outcome = 1;
    a = int'(fb[1]);
    d = {fb[5], fb[4], fb[3], fb[2]};
    if (fb[0] == 8'h01) m_reg[a] = (m_w[a] == 32) ? d : (d & ((32'd1 << m_w[a]) - 32'd1));
    else begin m_rd_data = m_reg[a]; m_rd_valid = 1; end
  endtask

  function automatic void set_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                    input logic [31:0] data, input logic [7:0] crc_xor);
    fb[0] = cmd; fb[1] = addr;
    fb[2] = data[7:0]; fb[3] = data[15:8]; fb[4] = data[23:16]; fb[5] = data[31:24];
    fb[6] = crc8(6) ^ crc_xor;
  endfunction

  // Drives one frame of nb bytes and samples the pulse outputs around the commit edge.
  task automatic send_frame(input int nb);
    @(posedge clk); #1 spi_ss = 0;
    @(posedge clk); #1;
    for (int k = 0; k < nb; k++) begin
      rx_valid = 1; rx_byte = fb[k]; crc_in = crc8(k + 1);
      @(posedge clk); #1 rx_valid = 0;
      if (k < nb - 1) repeat ($urandom_range(0, g_gap)) begin @(posedge clk); #1; end
    end
    if (nb < 7) spi_ss = 1;
    @(negedge clk); s_pre_ok  = frame_ok; s_pre_err  = frame_err;
    @(negedge clk); s_ok      = frame_ok; s_err      = frame_err;
    @(negedge clk); s_post_ok = frame_ok; s_post_err = frame_err;
    if (g_extra && nb >= 7) begin
      @(posedge clk); #1 rx_valid = 1; rx_byte = 8'($urandom); crc_in = 8'($urandom);
      @(posedge clk); #1 rx_valid = 0;
    end
    @(posedge clk); #1 spi_ss = 1;
    @(posedge clk); #1;
    model_frame(nb);
  endtask

  task automatic test_reset();
    rst = 1; spi_ss = 1; rx_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cfg_of(i) !== m_rst[i]) begin n_fail++; $display("FAIL reset_cfg%0d: got %h want %h", i, cfg_of(i), m_rst[i]); end
    end
    n_cmp++;
    if ({rd_data, rd_valid, frame_ok, frame_err, last_err, err_cnt} !== 45'd0) begin
      n_fail++; $display("FAIL reset_status: got %h/%b/%b/%b/%0d/%0d want all zero", rd_data, rd_valid, frame_ok, frame_err, last_err, err_cnt);
    end
  endtask

  task automatic test_write_stwd();
    set_frame(8'h01, 8'h01, 32'h5, 8'h00);
    send_frame(7);
    n_cmp++;
    if ({s_pre_ok, s_ok, s_post_ok, s_err} !== 4'b0100) begin
      n_fail++; $display("FAIL stwd_pulse: got pre/ok/post/err %b%b%b%b want 0100", s_pre_ok, s_ok, s_post_ok, s_err);
    end
    n_cmp++;
    if (cfg_stwd !== 4'd5 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL stwd_value: got stwd %0d err_cnt %0d want 5 0", cfg_stwd, err_cnt);
    end
  endtask

  task automatic test_bad_crc();
    set_frame(8'h01, 8'h06, 32'h1234, 8'h01);
    send_frame(7);
    n_cmp++;
    if ({s_ok, s_err} !== 2'b01 || cfg_off14 !== 24'd2752 || last_err !== 2'd1 || err_cnt !== 8'd1) begin
      n_fail++; $display("FAIL bad_crc: got ok/err %b%b off14 %0d last_err %0d err_cnt %0d want 01 2752 1 1", s_ok, s_err, cfg_off14, last_err, err_cnt);
    end
  endtask

  task automatic test_short_frame();
    logic [7:0] cnt_before;
    set_frame(8'h01, 8'h03, 32'd99, 8'h00);
    send_frame(4);
    n_cmp++;
    if ({s_pre_err, s_err, s_post_err} !== 3'b010 || last_err !== 2'd2 || cfg_filt_nogap !== 19'd45) begin
      n_fail++; $display("FAIL short4: got err %b%b%b last_err %0d nogap %0d want 010 2 45", s_pre_err, s_err, s_post_err, last_err, cfg_filt_nogap);
    end
    cnt_before = err_cnt;
    send_frame(0);
    n_cmp++;
    if (s_err !== 1'b0 || err_cnt !== cnt_before || err_cnt !== 8'(m_err_cnt)) begin
      n_fail++; $display("FAIL short0: got err %b err_cnt %0d want 0 %0d", s_err, err_cnt, m_err_cnt);
    end
  endtask

  task automatic test_read_back();
    set_frame(8'h01, 8'h02, 32'h0000_0EFF, 8'h00);
    send_frame(7);
    set_frame(8'h02, 8'h02, 32'hDEAD_BEEF, 8'h00);
    send_frame(7);
    n_cmp++;
    if (rd_data !== 32'h0000_0EFF || rd_valid !== 1'b1 || s_ok !== 1'b1) begin
      n_fail++; $display("FAIL read_back: got %h valid %b ok %b want 00000eff 1 1", rd_data, rd_valid, s_ok);
    end
    // First byte of the next frame drops rd_valid but keeps the data.
    @(posedge clk); #1 spi_ss = 0;
    @(posedge clk); #1 rx_valid = 1; rx_byte = 8'h01; crc_in = 8'h00;
    @(posedge clk); #1 rx_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h0000_0EFF || cfg_maxacr !== 24'd3839) begin
      n_fail++; $display("FAIL read_clear: got valid %b data %h maxacr %0d want 0 00000eff 3839", rd_valid, rd_data, cfg_maxacr);
    end
    @(posedge clk); #1 spi_ss = 1;
    repeat (2) @(posedge clk);
    #1 model_frame(1);
    n_cmp++;
    if (last_err !== 2'd2 || err_cnt !== 8'(m_err_cnt)) begin
      n_fail++; $display("FAIL read_abort: got last_err %0d err_cnt %0d want 2 %0d", last_err, err_cnt, m_err_cnt);
    end
  endtask

  task automatic test_bad_cmd();
    set_frame(8'h03, 8'h01, 32'h7, 8'h00);
    send_frame(7);
    n_cmp++;
    if (last_err !== 2'd3 || s_err !== 1'b1 || cfg_stwd !== 4'd5) begin
      n_fail++; $display("FAIL bad_cmd: got last_err %0d err %b stwd %0d want 3 1 5", last_err, s_err, cfg_stwd);
    end
    set_frame(8'h01, 8'h08, 32'h7, 8'h00);
    send_frame(7);
    n_cmp++;
    if (last_err !== 2'd3 || s_err !== 1'b1 || err_cnt !== 8'(m_err_cnt)) begin
      n_fail++; $display("FAIL bad_addr: got last_err %0d err %b cnt %0d want 3 1 %0d", last_err, s_err, err_cnt, m_err_cnt);
    end
  endtask

  task automatic test_random(input int n, input string tag);
    logic [7:0] cmd;
    int nb;
    for (int t = 0; t < n; t++) begin
      case ($urandom_range(0, 4))
        0, 1:    cmd = 8'h01;
        2, 3:    cmd = 8'h02;
        default: cmd = 8'($urandom);
      endcase
      set_frame(cmd, 8'($urandom_range(0, 9)), $urandom,
                ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      nb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : 7;
      send_frame(nb);
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (cfg_of(i) !== m_reg[i]) begin n_fail++; $display("FAIL %s_cfg%0d: frame %0d got %h want %h", tag, i, t, cfg_of(i), m_reg[i]); end
      end
      n_cmp++;
      if ({rd_valid, rd_data, last_err, err_cnt} !== {m_rd_valid, m_rd_data, m_last_err, 8'(m_err_cnt)}) begin
        n_fail++; $display("FAIL %s_status: frame %0d got %b %h %0d %0d want %b %h %0d %0d", tag, t,
                           rd_valid, rd_data, last_err, err_cnt, m_rd_valid, m_rd_data, m_last_err, m_err_cnt);
      end
      n_cmp++;
      if ({s_pre_ok, s_pre_err, s_ok, s_err, s_post_ok, s_post_err} !== {2'b00, m_outcome == 1, m_outcome == 2, 2'b00}) begin
        n_fail++; $display("FAIL %s_pulse: frame %0d got %b%b%b%b%b%b outcome %0d", tag, t,
                           s_pre_ok, s_pre_err, s_ok, s_err, s_post_ok, s_post_err, m_outcome);
      end
    end
  endtask

  task automatic test_back_to_back();
    g_gap = 0; g_extra = 1;
    test_random(12, "b2b");
    g_gap = 1; g_extra = 0;
  endtask

  task automatic test_saturate();
    for (int t = 0; t < 260; t++) begin
      set_frame(8'h01, 8'h08, 32'h0, 8'h00);
      send_frame(7);
    end
    n_cmp++;
    if (err_cnt !== 8'd255 || m_err_cnt != 255 || last_err !== 2'd3) begin
      n_fail++; $display("FAIL saturate: got err_cnt %0d last_err %0d want 255 3", err_cnt, last_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    set_frame(8'h01, 8'h05, 32'h1111, 8'h00);
    @(posedge clk); #1 spi_ss = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      rx_valid = 1; rx_byte = fb[k]; crc_in = crc8(k + 1);
      @(posedge clk); #1 rx_valid = 0;
    end
    rst = 1;
    @(posedge clk); #1 rst = 0; spi_ss = 1;
    model_reset();
    @(posedge clk); #1;
    set_frame(8'h01, 8'h03, 32'd60, 8'h00);
    send_frame(7);
    n_cmp++;
    if (cfg_filt_nogap !== 19'd60 || err_cnt !== 8'd0 || s_ok !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid: got nogap %0d err_cnt %0d ok %b want 60 0 1", cfg_filt_nogap, err_cnt, s_ok);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cfg_of(i) !== m_reg[i]) begin n_fail++; $display("FAIL rst_mid_cfg%0d: got %h want %h", i, cfg_of(i), m_reg[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_stwd();
    test_bad_crc();
    test_short_frame();
    test_read_back();
    test_bad_cmd();
    test_random(60, "rnd");
    test_back_to_back();
    test_saturate();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
